and_or_pipe: RTL and testbench

Parametrised, registered successor to the combinational `base_and_or` logic unit. It adds a valid/ready handshake on both sides, a 2-entry output buffer, and a burst-accumulate mode that folds a stream of operands into one result. It sits between an operand producer and a result consumer, and sustains one operation per cycle when the consumer does not stall.

---
 rtl/and_or_pipe.sv | 129 ++++++++++++
 tb/tb_and_or_pipe.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/and_or_pipe.sv
// and_or_pipe: registered AND/OR(/XOR) unit with valid/ready handshake, 2-entry output FIFO and burst accumulate
// Ports: clk, rst (async, active-high); input side in_valid_i/in_ready_o, a_i, b_i, do_and_i, do_or_i,
// do_xor_i (only with AND_OR_XOR_EN), acc_mode_i, in_last_i; output side out_valid_o/out_ready_i,
// out_o, is_and_o, is_err_o, beat_count_o presenting the FIFO head (all zero when empty).
// Macro AND_OR_XOR_EN adds the do_xor_i port and XOR as a third op.
module and_or_pipe #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             do_and_i,
  input  logic             do_or_i,
`ifdef AND_OR_XOR_EN
  input  logic             do_xor_i,
`endif
  input  logic             acc_mode_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_o,
  output logic             is_and_o,
  output logic             is_err_o,
  output logic [CNT_W-1:0] beat_count_o
);
  typedef struct packed {
    logic [WIDTH-1:0] val;
    logic             is_and;
    logic             is_err;
    logic [CNT_W-1:0] cnt;
  } entry_t;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state_q, state_d;
  entry_t head_q, head_d, tail_q, tail_d, new_e;
  logic [WIDTH-1:0] acc_q, acc_d, single_v, step_v, fold_v;
  logic [CNT_W-1:0] cnt_q, cnt_d, fold_cnt;
  logic err_q, err_d, open_q, open_d, fold_err, in_ready_q;
  logic do_xor, beat_err, beat_and, accept, push, pop;
`ifdef AND_OR_XOR_EN
  assign do_xor = do_xor_i;
`else
  assign do_xor = 1'b0;
`endif
  assign beat_err = (do_and_i & do_or_i) | (do_and_i & do_xor) | (do_or_i & do_xor);
  assign beat_and = do_and_i & ~do_or_i & ~do_xor;
  // the registered ready is forced low while reset is held
  assign in_ready_o = in_ready_q & ~rst;
  assign accept = in_valid_i & in_ready_o;
  assign push = accept & (~acc_mode_i | in_last_i);
  assign out_valid_o = state_q != EMPTY;
  assign pop = out_valid_o & out_ready_i;
  assign out_o = out_valid_o ? head_q.val : '0;
  assign is_and_o = out_valid_o & head_q.is_and;
  assign is_err_o = out_valid_o & head_q.is_err;
  assign beat_count_o = out_valid_o ? head_q.cnt : '0;
  always_comb begin
    single_v = beat_err ? '0 : do_and_i ? a_i & b_i : do_or_i ? a_i | b_i : do_xor ? a_i ^ b_i : a_i;
    step_v = beat_err ? '0 : do_and_i ? acc_q & a_i : do_or_i ? acc_q | a_i : do_xor ? acc_q ^ a_i : acc_q;
    fold_v = open_q ? step_v : a_i;
    fold_err = beat_err | (open_q & err_q);
    fold_cnt = !open_q ? CNT_W'(1) : &cnt_q ? cnt_q : cnt_q + 1'b1;
    new_e.val = acc_mode_i ? (fold_err ? '0 : fold_v) : single_v;
    new_e.is_and = beat_and;
    new_e.is_err = acc_mode_i ? fold_err : beat_err;
    new_e.cnt = acc_mode_i ? fold_cnt : CNT_W'(1);
  end
  // single beats leave an open burst untouched; the last beat closes and clears it
  always_comb begin
    open_d = open_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (accept && acc_mode_i) begin
      open_d = ~in_last_i;
      acc_d = in_last_i ? '0 : fold_v;
      cnt_d = in_last_i ? '0 : fold_cnt;
      err_d = ~in_last_i & fold_err;
    end
  end
  always_comb begin
    state_d = state_q;
    head_d = head_q;
    tail_d = tail_q;
    case (state_q)
      EMPTY: if (push) begin
        state_d = ONE;
        head_d = new_e;
      end
      ONE: if (push && pop) head_d = new_e;
      else if (push) begin
        tail_d = new_e;
        state_d = FULL;
      end else if (pop) begin
        head_d = '0;
        state_d = EMPTY;
      end
      default: if (pop) begin
        head_d = tail_q;
        tail_d = '0;
        state_d = ONE;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q <= '0;
      tail_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      open_q <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      head_q <= head_d;
      tail_q <= tail_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      open_q <= open_d;
      in_ready_q <= state_d != FULL;
    end
  end
endmodule

// File: tb/tb_and_or_pipe.sv
// tb_and_or_pipe: self-checking bench for and_or_pipe (default build, WIDTH=4, CNT_W=4)
module tb_and_or_pipe;
  typedef struct packed {
    logic [3:0] val;
    logic       is_and;
    logic       is_err;
    logic [3:0] cnt;
  } exp_t;
  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       fa;
    logic       fo;
    exp_t       e;
  } vec_t;
  logic clk = 0, rst = 1, in_valid = 0, do_and = 0, do_or = 0, acc_mode = 0, in_last = 0, out_ready = 0;
  logic in_ready, out_valid, is_and, is_err;
  logic [3:0] a = 0, b = 0, out, beat_count;
  int tests = 0, fails = 0, stalls = 0;
  exp_t q[$];
  exp_t held;
  bit has_held = 0;
  always #5 clk = ~clk;
  and_or_pipe dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready), .a_i(a), .b_i(b),
    .do_and_i(do_and), .do_or_i(do_or), .acc_mode_i(acc_mode), .in_last_i(in_last),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_o(out), .is_and_o(is_and),
    .is_err_o(is_err), .beat_count_o(beat_count)
  );
  function automatic exp_t mk(input logic [3:0] v, input logic ia, input logic ie, input logic [3:0] c);
    return {v, ia, ie, c};
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic send(input logic [3:0] av, input logic [3:0] bv, input logic fa, input logic fo,
                      input logic am, input logic last, input bit exp_push, input exp_t e);
    int n = 0;
    a = av; b = bv; do_and = fa; do_or = fo; acc_mode = am; in_last = last; in_valid = 1;
    if (exp_push) q.push_back(e);
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      stalls++;
      @(negedge clk);
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL accept: beat a=%0h not accepted within 50 cycles", av);
    end
    @(posedge clk);
    #1 in_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("drain_left", q.size(), 0);
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    exp_t got, e;
    got = {out, is_and, is_err, beat_count};
    if (rst) has_held = 0;
    else begin
      if (has_held) begin
        check("hold_valid", out_valid, 1);
        check("hold_entry", got, held);
      end
      has_held = out_valid && !out_ready;
      held = got;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL pop: unexpected entry %0h, none required", got);
        end else begin
          e = q.pop_front();
          check("pop_entry", got, e);
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, required to finish");
    $fatal(1, "timeout");
  end
  initial begin
    vec_t v[6];
    v[0] = '{4'b0101, 4'b0011, 1'b1, 1'b0, mk(4'b0001, 1, 0, 1)};
    v[1] = '{4'b0101, 4'b0011, 1'b0, 1'b1, mk(4'b0111, 0, 0, 1)};
    v[2] = '{4'b1111, 4'b1111, 1'b1, 1'b1, mk(4'b0000, 0, 1, 1)};
    v[3] = '{4'b1010, 4'b0110, 1'b0, 1'b0, mk(4'b1010, 0, 0, 1)};
    v[4] = '{4'b1100, 4'b1010, 1'b1, 1'b0, mk(4'b1000, 1, 0, 1)};
    v[5] = '{4'b0000, 4'b1111, 1'b0, 1'b1, mk(4'b1111, 0, 0, 1)};
    #1;
    check("rst_ready", in_ready, 0);
    check("rst_valid", out_valid, 0);
    check("rst_entry", {out, is_and, is_err, beat_count}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("ready_after_rst", in_ready, 1);
    check("idle_valid", out_valid, 0);
    @(posedge clk);
    #1 out_ready = 1;
    send(v[0].a, v[0].b, v[0].fa, v[0].fo, 0, 0, 1, v[0].e);
    @(negedge clk);
    check("latency_valid", out_valid, 1);
    check("latency_out", out, 4'b0001);
    @(posedge clk);
    #1 stalls = 0;
    for (int i = 1; i < 6; i++) send(v[i].a, v[i].b, v[i].fa, v[i].fo, 0, 0, 1, v[i].e);
    check("throughput_stalls", stalls, 0);
    drain();
    out_ready = 0;
    send(4'b1111, 4'b0001, 1, 0, 0, 0, 1, mk(4'b0001, 1, 0, 1));
    send(4'b1111, 4'b0010, 1, 0, 0, 0, 1, mk(4'b0010, 1, 0, 1));
    fork
      send(4'b1111, 4'b0100, 1, 0, 0, 0, 1, mk(4'b0100, 1, 0, 1));
      begin
        @(negedge clk);
        check("full_ready", in_ready, 0);
        check("full_valid", out_valid, 1);
        repeat (3) @(negedge clk);
        check("stall_ready", in_ready, 0);
        @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain();
    send(4'b1111, 4'b0000, 1, 0, 1, 0, 0, '0);
    send(4'b0101, 4'b0011, 0, 1, 0, 0, 1, mk(4'b0111, 0, 0, 1));
    send(4'b1101, 4'b0000, 1, 0, 1, 0, 0, '0);
    send(4'b0111, 4'b0000, 1, 0, 1, 1, 1, mk(4'b0101, 1, 0, 3));
    drain();
    send(4'b1000, 4'b0000, 1, 0, 1, 0, 0, '0);
    send(4'b0110, 4'b0000, 1, 1, 1, 0, 0, '0);
    send(4'b1111, 4'b0000, 0, 1, 1, 1, 1, mk(4'b0000, 0, 1, 3));
    drain();
    for (int i = 0; i < 16; i++) send(4'b0001, 4'b0000, 0, 1, 1, 0, 0, '0);
    send(4'b0001, 4'b0000, 0, 1, 1, 1, 1, mk(4'b0001, 0, 0, 15));
    drain();
    out_ready = 0;
    send(4'b0001, 4'b0000, 1, 0, 1, 0, 0, '0);
    send(4'b0011, 4'b0101, 1, 0, 0, 0, 1, mk(4'b0001, 1, 0, 1));
    send(4'b0011, 4'b0101, 0, 1, 0, 0, 1, mk(4'b0111, 0, 0, 1));
    @(negedge clk);
    check("pre_rst_ready", in_ready, 0);
    #2 rst = 1;
    q.delete();
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_ready", in_ready, 0);
    check("async_rst_entry", {out, is_and, is_err, beat_count}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rerst_ready", in_ready, 1);
    check("rerst_valid", out_valid, 0);
    @(posedge clk);
    #1 out_ready = 1;
    send(4'b1010, 4'b0000, 1, 0, 1, 1, 1, mk(4'b1010, 1, 0, 1));
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
